pe_dc_unpool: RTL and testbench
===============================

Name: pe_dc_unpool

Overview:
- Decoder-side max-unpooling stage for the binary encoder-decoder datapath.
- Consumes pooled binary activations plus the per-channel pooling index produced by the encoder PEs.
- Emits the full-resolution map in raster order. Each bit is placed at its recorded window position; every other position is filled with 0.
- Sits between the pindex/activation buffers and the first decoder convolution line buffer.

Parameters:
- C, 64, channels per pixel (one pooled bit and one index per channel)
- POOL_H, 2, pooling window height
- POOL_W, 2, pooling window width
- MAX_WP, 32, maximum pooled row width held in the line buffer
- PINDEX_WIDTH, $clog2(POOL_H*POOL_W), index width per channel (localparam)
- WP_WIDTH, $clog2(MAX_WP+1), row-length counter width (localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_wp  in  WP_WIDTH  pooled pixels per row; sampled on IDLE->ROW0
- in_valid  in  1  pooled pixel valid
- in_ready  out  1  pooled pixel accepted when in_valid&in_ready
- in_data  in  C  pooled binary activation, bit c = channel c
- in_pindex  in  C*PINDEX_WIDTH  channel c index at [c*PINDEX_WIDTH +: PINDEX_WIDTH]; value = i*POOL_W+j
- out_valid  out  1  unpooled pixel valid
- out_ready  in  1  downstream accept
- out_data  out  C  unpooled pixel
- out_row_last  out  1  marks last pixel of each output row
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: state IDLE, in_ready=0, out_valid=0, out_data=0, out_row_last=0, busy=0, all counters 0. Line buffer contents are don't-care.
- Reset mid-row discards all partial state. The next row starts fresh from IDLE.
- Output register: out_* are registered and hold stable while out_valid&!out_ready (AXI-stream rules). in_ready never combinationally depends on in_valid.
- FSM IDLE:
  - Sample wp = (cfg_wp > MAX_WP) ? MAX_WP : cfg_wp.
  - If wp == 0, remain IDLE.
  - Otherwise go to ROW0 next cycle with col=0, j=0.
- FSM ROW0 (output window row i=0):
  - in_ready = 1 when no beat is pending, or the pending beat is j=POOL_W-1 and out_ready=1.
  - On accept: write {in_data, in_pindex} to linebuf[col] and hold them in an input register.
  - Emit POOL_W beats j=0..POOL_W-1, each advancing on out_ready.
  - Beat value: out_data[c] = in_data[c] & (pindex_c == i*POOL_W+j).
  - After the beat col=wp-1, j=POOL_W-1 is taken: go to ROWN with i=1, col=0, j=0.
  - Steady-state throughput: one input per POOL_W cycles, zero bubbles with out_ready held high.
  - First out_valid occurs one cycle after the first accept.
- FSM ROWN (i=1..POOL_H-1):
  - in_ready=0. Read linebuf[col] and emit POOL_W beats per entry using the same formula with the current i.
  - Buffer read is registered. The read address is prefetched so consecutive beats have no bubble when out_ready=1.
  - After col=wp-1, j=POOL_W-1 of row i=POOL_H-1: return to IDLE, which resamples cfg_wp.
- out_row_last = 1 exactly on the beat with col=wp-1 and j=POOL_W-1, in every output row.
- Index values >= POOL_H*POOL_W match no position: that channel outputs 0 for the whole window.
- Backpressure: out_ready low freezes all counters and the FSM. No data is lost or duplicated.
- Per pooled row: exactly POOL_H*POOL_W*wp output beats and wp input accepts.

Optional Feature:
- Macro: UNPOOL_REPLICATE_EN.
- Defined: in_pindex is ignored; out_data = in_data (or buffered data) at every window position (nearest-neighbour upsample). The buffer stores data only, and the index storage is not instantiated.
- Undefined: index-directed unpooling as specified above.
- Handshake, timing and out_row_last are identical in both builds.

Test Plan:
- Zero-fill: C=4, 2x2, cfg_wp=1, in_data=4'b1111, indices {3,2,1,0} (ch3..ch0), out_ready=1 -> 4 beats 4'b0001, 4'b0010, 4'b0100, 4'b1000; out_row_last on beats 2 and 4.
- Full row and throughput: cfg_wp=32, random data/indices, out_ready=1 -> 128 beats matching the golden model; in_ready pattern 1,0 alternating during ROW0; no out_valid gaps after the first beat; busy falls after the 128th beat.
- Backpressure: out_ready random 30% low -> output stream identical to the out_ready=1 run; out_data stable while stalled.
- Boundaries: cfg_wp=0 -> stays IDLE, in_ready=0; cfg_wp=40 -> clamped, 32 accepts and 128 beats; pindex=3'b111 on a channel with PINDEX_WIDTH=3 (POOL 2x3) -> that channel outputs 0 for the whole window.
- Reset mid-operation: assert rst_n=0 during ROWN col=5 -> next cycle out_valid=0, busy=0; a fresh row with cfg_wp=2 then produces exactly 8 correct beats.
- UNPOOL_REPLICATE_EN defined: in_data=4'b1010, any pindex, cfg_wp=1 -> 4 beats all 4'b1010.

Source files
------------

// File: rtl/pe_dc_unpool.sv
// Decoder max-unpooling: scatters each pooled bit to its recorded window slot, zero elsewhere, raster order.
// Build macro UNPOOL_REPLICATE_EN: ignore in_pindex and replicate data over the window (no index storage).
module pe_dc_unpool #(
    parameter  int C            = 64,
    parameter  int POOL_H       = 2,
    parameter  int POOL_W       = 2,
    parameter  int MAX_WP       = 32,
    localparam int PINDEX_WIDTH = $clog2(POOL_H*POOL_W),
    localparam int WP_WIDTH     = $clog2(MAX_WP+1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WP_WIDTH-1:0]       cfg_wp,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [C-1:0]              in_data,
    input  logic [C*PINDEX_WIDTH-1:0] in_pindex,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [C-1:0]              out_data,
    output logic                      out_row_last,
    output logic                      busy
);

    localparam int I_W   = (POOL_H > 1) ? $clog2(POOL_H) : 1;
    localparam int J_W   = (POOL_W > 1) ? $clog2(POOL_W) : 1;
    localparam int COL_W = (MAX_WP > 1) ? $clog2(MAX_WP) : 1;
`ifdef UNPOOL_REPLICATE_EN
    localparam int WORD_W = C;
`else
    localparam int WORD_W = C + C*PINDEX_WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW0 = 2'd1,
        ROWN = 2'd2
    } state_t;

    state_t              state_r;
    logic [WP_WIDTH-1:0] wp_r;
    logic [COL_W-1:0]    gcol_r;
    logic [I_W-1:0]      gi_r;
    logic [J_W-1:0]      gj_r;
    logic                gen_done_r;
    logic                out_final_r;
    logic [WORD_W-1:0]   src_r;
    logic [WORD_W-1:0]   linebuf_r [MAX_WP];

    logic [WP_WIDTH-1:0] wp_clamp_s;
    logic [WORD_W-1:0]   in_word_s;
    logic [WORD_W-1:0]   beat_word_s;
    logic [WORD_W-1:0]   rd_word_s;
    logic [C-1:0]        beat_s;
    logic [COL_W-1:0]    last_col_s;
    logic [COL_W-1:0]    ncol_s;
    logic [I_W-1:0]      ni_s;
    logic [J_W-1:0]      nj_s;
    logic                gen_active_s;
    logic                need_input_s;
    logic                slot_free_s;
    logic                load_s;
    logic                fire_in_s;
    logic                row_last_s;
    logic                final_s;
    logic                prefetch_s;

`ifdef UNPOOL_REPLICATE_EN
    logic unused_pindex_s;
    assign unused_pindex_s = ^in_pindex;
    assign in_word_s       = in_data;
`else
    assign in_word_s = {in_pindex, in_data};
`endif

    assign busy = (state_r != IDLE);

    // Generator control: the generator runs one beat ahead of the output register.
    always_comb begin
        wp_clamp_s   = (cfg_wp > WP_WIDTH'(MAX_WP)) ? WP_WIDTH'(MAX_WP) : cfg_wp;
        last_col_s   = COL_W'(wp_r - WP_WIDTH'(1));
        gen_active_s = (state_r != IDLE) && !gen_done_r;
        need_input_s = (gi_r == I_W'(0)) && (gj_r == J_W'(0));
        slot_free_s  = !out_valid || out_ready;
        in_ready     = (state_r == ROW0) && gen_active_s && need_input_s && slot_free_s;
        fire_in_s    = in_ready && in_valid;
        load_s       = gen_active_s && slot_free_s && (!need_input_s || in_valid);
        row_last_s   = (gcol_r == last_col_s) && (gj_r == J_W'(POOL_W-1));
        final_s      = row_last_s && (gi_r == I_W'(POOL_H-1));
        beat_word_s  = need_input_s ? in_word_s : src_r;
    end

    // Next window position in raster order (j fastest, then column, then window row).
    always_comb begin
        nj_s   = gj_r + J_W'(1);
        ncol_s = gcol_r;
        ni_s   = gi_r;
        if (gj_r == J_W'(POOL_W-1)) begin
            nj_s = J_W'(0);
            if (gcol_r == last_col_s) begin
                ncol_s = COL_W'(0);
                ni_s   = gi_r + I_W'(1);
            end else begin
                ncol_s = gcol_r + COL_W'(1);
            end
        end else begin
            nj_s = gj_r + J_W'(1);
        end
        // Fetch the next entry one beat early so buffered rows stream without bubbles.
        prefetch_s = load_s && !final_s && (nj_s == J_W'(0)) && (ni_s != I_W'(0));
        if (fire_in_s && (gcol_r == ncol_s)) begin
            rd_word_s = in_word_s;
        end else begin
            rd_word_s = linebuf_r[ncol_s];
        end
    end

`ifdef UNPOOL_REPLICATE_EN
    // Nearest-neighbour beat: data repeated at every window position.
    always_comb begin
        beat_s = beat_word_s[C-1:0];
    end
`else
    logic [PINDEX_WIDTH-1:0] pos_s;

    function automatic logic [C-1:0] unpool_beat_f(input logic [WORD_W-1:0] word,
                                                   input logic [PINDEX_WIDTH-1:0] pos);
        logic [C-1:0] beat;
        beat = '0;
        for (int c = 0; c < C; c++) begin
            beat[c] = word[c] & (word[C + c*PINDEX_WIDTH +: PINDEX_WIDTH] == pos);
        end
        return beat;
    endfunction

    // Index-directed beat: a channel fires only at its recorded window slot.
    always_comb begin
        pos_s  = PINDEX_WIDTH'(int'(gi_r) * POOL_W + int'(gj_r));
        beat_s = unpool_beat_f(beat_word_s, pos_s);
    end
`endif

    // Line buffer write for pooled row entries; contents need no reset.
    always_ff @(posedge clk) begin
        if (fire_in_s) begin
            linebuf_r[gcol_r] <= in_word_s;
        end
    end

    // FSM, generator counters, source register and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            wp_r         <= '0;
            gcol_r       <= '0;
            gi_r         <= '0;
            gj_r         <= '0;
            gen_done_r   <= 1'b0;
            src_r        <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_row_last <= 1'b0;
            out_final_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wp_r       <= wp_clamp_s;
                    gcol_r     <= '0;
                    gi_r       <= '0;
                    gj_r       <= '0;
                    gen_done_r <= 1'b0;
                    state_r    <= (wp_clamp_s != WP_WIDTH'(0)) ? ROW0 : IDLE;
                end
                ROW0, ROWN: begin
                    if (load_s) begin
                        gi_r       <= ni_s;
                        gcol_r     <= ncol_s;
                        gj_r       <= nj_s;
                        gen_done_r <= final_s;
                    end
                    // FSM follows the taken beat, not the generator.
                    if (out_valid && out_ready) begin
                        if (out_final_r) begin
                            state_r <= IDLE;
                        end else if (out_row_last && (state_r == ROW0)) begin
                            state_r <= ROWN;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            if (load_s) begin
                out_valid    <= 1'b1;
                out_data     <= beat_s;
                out_row_last <= row_last_s;
                out_final_r  <= final_s;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (prefetch_s) begin
                src_r <= rd_word_s;
            end else if (fire_in_s) begin
                src_r <= in_word_s;
            end
        end
    end

endmodule

// File: tb/tb_pe_dc_unpool.sv
// Self-checking bench for pe_dc_unpool: randomized rows against a window-level reference model.
module tb_pe_dc_unpool;
    localparam int C = 4, PH = 2, PW = 2, MWP = 32, PIW = 2, WPW = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic [WPW-1:0] cfg_wp;
    logic in_valid, in_ready, out_valid, out_ready, out_row_last, busy;
    logic [C-1:0] in_data, out_data;
    logic [C*PIW-1:0] in_pindex;

    logic [2:0]  b_cfg_wp;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_row_last, b_busy;
    logic [3:0]  b_in_data, b_out_data;
    logic [11:0] b_in_pindex;

    pe_dc_unpool #(.C(C), .POOL_H(PH), .POOL_W(PW), .MAX_WP(MWP)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wp(cfg_wp), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pindex(in_pindex), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row_last(out_row_last), .busy(busy)
    );

    pe_dc_unpool #(.C(4), .POOL_H(2), .POOL_W(3), .MAX_WP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_wp(b_cfg_wp), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_pindex(b_in_pindex), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_row_last(b_out_row_last), .busy(b_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [C-1:0]     px_data [40];
    logic [C*PIW-1:0] px_idx  [40];
    logic [C-1:0] obs_q[$], exp_q[$], ref_q[$];
    logic         obs_last_q[$], exp_last_q[$], rdy_q[$];
    int   acc_cnt, gap_cnt, stall_bad, timed_out;
    logic busy_after;

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            px_data[k] = C'($urandom);
            px_idx[k]  = (C*PIW)'($urandom);
        end
    endtask

    // Reference: walk every window row, pooled column and window column of the row.
    task automatic build_expected(input int wp_cfg);
        int wp;
        int idx;
        logic [C-1:0] b;
        wp = (wp_cfg > MWP) ? MWP : wp_cfg;
        exp_q.delete();
        exp_last_q.delete();
        for (int i = 0; i < PH; i++)
            for (int col = 0; col < wp; col++)
                for (int j = 0; j < PW; j++) begin
                    for (int c = 0; c < C; c++) begin
                        idx = int'((px_idx[col] >> (c*PIW)) % (1 << PIW));
`ifdef UNPOOL_REPLICATE_EN
                        b[c] = px_data[col][c];
`else
                        b[c] = px_data[col][c] && (idx == i*PW + j);
`endif
                    end
                    exp_q.push_back(b);
                    exp_last_q.push_back((col == wp-1) && (j == PW-1));
                end
    endtask

    // Drives one pooled row into dut and records everything observed at the output.
    task automatic run_stream(input int wp_cfg, input int low_pct, input int stop_after, input int max_cycles);
        int nwp, target, taken, offer;
        logic first_valid, prev_stall, fin;
        logic [C-1:0] prev_data;
        nwp    = (wp_cfg > MWP) ? MWP : wp_cfg;
        offer  = (wp_cfg > 40) ? 40 : wp_cfg;
        target = PH*PW*nwp;
        taken = 0; acc_cnt = 0; gap_cnt = 0; stall_bad = 0; timed_out = 1;
        first_valid = 1'b0; prev_stall = 1'b0; prev_data = '0;
        obs_q.delete(); obs_last_q.delete(); rdy_q.delete();
        @(negedge clk);
        cfg_wp = WPW'(wp_cfg);
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = ($urandom_range(99) >= low_pct);
            in_valid  = (acc_cnt < offer);
            in_data   = px_data[acc_cnt % 40];
            in_pindex = px_idx[acc_cnt % 40];
            #1;
            if (prev_stall && (out_data !== prev_data)) stall_bad++;
            if ((acc_cnt < nwp) && (acc_cnt > 0 || in_ready)) rdy_q.push_back(in_ready);
            if (out_valid) first_valid = 1'b1;
            if (first_valid && !out_valid && taken < target) gap_cnt++;
            if (out_valid && out_ready) begin
                obs_q.push_back(out_data);
                obs_last_q.push_back(out_row_last);
                taken++;
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                cfg_wp = '0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            fin = (taken >= target) || (taken >= stop_after);
            if (fin) begin
                timed_out = 0;
                break;
            end
        end
        @(posedge clk);
        in_valid = 1'b0;
        cfg_wp   = '0;
        if (stop_after > target) begin
            @(negedge clk);
            #1;
            busy_after = busy;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_wp = '0; in_data = '0; in_pindex = '0;
        b_cfg_wp = '0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0; b_in_pindex = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
        n_checks++; if (out_row_last !== 1'b0) begin n_fail++; $display("FAIL reset_row_last got=%b exp=0", out_row_last); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_fill;
        logic [3:0] e_data [4];
        logic       e_last [4];
`ifdef UNPOOL_REPLICATE_EN
        px_data[0] = 4'b1010;
        e_data = '{4'b1010, 4'b1010, 4'b1010, 4'b1010};
`else
        px_data[0] = 4'b1111;
        e_data = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        px_idx[0] = {2'd3, 2'd2, 2'd1, 2'd0};
        e_last = '{1'b0, 1'b1, 1'b0, 1'b1};
        run_stream(1, 0, 9999, 200);
        n_checks++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL zero_fill_count got=%0d exp=4", obs_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (obs_q[k] !== e_data[k]) begin n_fail++; $display("FAIL zero_fill_beat%0d got=%b exp=%b", k, obs_q[k], e_data[k]); end
                n_checks++; if (obs_last_q[k] !== e_last[k]) begin n_fail++; $display("FAIL zero_fill_last%0d got=%b exp=%b", k, obs_last_q[k], e_last[k]); end
            end
        end
    endtask

    task automatic test_full_row;
        fill_random(32);
        build_expected(32);
        run_stream(32, 0, 9999, 2000);
        n_checks++; if (timed_out != 0) begin n_fail++; $display("FAIL full_timeout got=%0d exp=0", timed_out); end
        n_checks++; if (acc_cnt != 32) begin n_fail++; $display("FAIL full_accepts got=%0d exp=32", acc_cnt); end
        n_checks++; if (obs_q.size() != 128) begin n_fail++; $display("FAIL full_count got=%0d exp=128", obs_q.size()); end
        else begin
            for (int k = 0; k < 128; k++) begin
                n_checks++; if (obs_q[k] !== exp_q[k] || obs_last_q[k] !== exp_last_q[k]) begin
                    n_fail++; $display("FAIL full_beat%0d got=%b/%b exp=%b/%b", k, obs_q[k], obs_last_q[k], exp_q[k], exp_last_q[k]); end
            end
        end
        n_checks++; if (rdy_q.size() != 63) begin n_fail++; $display("FAIL full_ready_len got=%0d exp=63", rdy_q.size()); end
        else begin
            for (int k = 0; k < 63; k++) begin
                n_checks++; if (rdy_q[k] !== ((k % 2) == 0)) begin n_fail++; $display("FAIL full_ready%0d got=%b exp=%b", k, rdy_q[k], (k % 2) == 0); end
            end
        end
        n_checks++; if (gap_cnt != 0) begin n_fail++; $display("FAIL full_gaps got=%0d exp=0", gap_cnt); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_busy_end got=%b exp=0", busy_after); end
    endtask

    task automatic test_backpressure;
        fill_random(12);
        build_expected(12);
        run_stream(12, 0, 9999, 1000);
        ref_q = obs_q;
        run_stream(12, 30, 9999, 3000);
        n_checks++; if (timed_out != 0) begin n_fail++; $display("FAIL bp_timeout got=%0d exp=0", timed_out); end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
        n_checks++; if (obs_q.size() != 48 || ref_q.size() != 48) begin
            n_fail++; $display("FAIL bp_count got=%0d/%0d exp=48", obs_q.size(), ref_q.size()); end
        else begin
            for (int k = 0; k < 48; k++) begin
                n_checks++; if (obs_q[k] !== ref_q[k] || obs_q[k] !== exp_q[k] || obs_last_q[k] !== exp_last_q[k]) begin
                    n_fail++; $display("FAIL bp_beat%0d got=%b ref=%b exp=%b", k, obs_q[k], ref_q[k], exp_q[k]); end
            end
        end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end got=%b exp=0", busy_after); end
    endtask

    task automatic test_wp_zero;
        @(negedge clk);
        cfg_wp = '0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wp0_busy got=%b exp=0", busy); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wp0_in_ready got=%b exp=0", in_ready); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_clamp;
        fill_random(40);
        build_expected(40);
        run_stream(40, 0, 9999, 2000);
        n_checks++; if (acc_cnt != 32) begin n_fail++; $display("FAIL clamp_accepts got=%0d exp=32", acc_cnt); end
        n_checks++; if (obs_q.size() != 128) begin n_fail++; $display("FAIL clamp_count got=%0d exp=128", obs_q.size()); end
        else begin
            for (int k = 0; k < 128; k++) begin
                n_checks++; if (obs_q[k] !== exp_q[k] || obs_last_q[k] !== exp_last_q[k]) begin
                    n_fail++; $display("FAIL clamp_beat%0d got=%b exp=%b", k, obs_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_invalid_index;
        logic [3:0] got[$];
        logic [3:0] e;
        logic [2:0] idx [4];
        logic       accepted;
        idx = '{3'd7, 3'd0, 3'd5, 3'd2};
        accepted = 1'b0;
        @(negedge clk);
        b_cfg_wp = 3'd1; b_in_valid = 1'b1; b_in_data = 4'b1111; b_out_ready = 1'b1;
        b_in_pindex = {idx[3], idx[2], idx[1], idx[0]};
        for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
            @(negedge clk);
            if (accepted) begin b_in_valid = 1'b0; b_cfg_wp = '0; end
            #1;
            if (b_out_valid) got.push_back(b_out_data);
            accepted = b_in_valid && b_in_ready;
        end
        b_in_valid = 1'b0; b_cfg_wp = '0;
        n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL idx7_count got=%0d exp=6", got.size()); end
        else begin
            for (int p = 0; p < 6; p++) begin
                for (int c = 0; c < 4; c++) begin
`ifdef UNPOOL_REPLICATE_EN
                    e[c] = 1'b1;
`else
                    e[c] = (int'(idx[c]) == p);
`endif
                end
                n_checks++; if (got[p] !== e) begin n_fail++; $display("FAIL idx7_beat%0d got=%b exp=%b", p, got[p], e); end
            end
        end
    endtask

    task automatic test_reset_mid;
        fill_random(8);
        run_stream(8, 0, 26, 500);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        fill_random(2);
        build_expected(2);
        run_stream(2, 0, 9999, 300);
        n_checks++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=8", obs_q.size()); end
        else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++; if (obs_q[k] !== exp_q[k] || obs_last_q[k] !== exp_last_q[k]) begin
                    n_fail++; $display("FAIL rstmid_beat%0d got=%b exp=%b", k, obs_q[k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_full_row();
        test_backpressure();
        test_wp_zero();
        test_clamp();
        test_invalid_index();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
